// File: rtl/mem_io_responder_pkg.sv
// rtl/mem_io_responder_pkg.sv - shared types and constants for the data-memory responder
package mem_io_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] DEFAULT_IO_BASE = 8'hF0;
    localparam int         RAM_DEPTH       = 240;

    // I/O register offsets from IO_BASE
    localparam logic [7:0] OFS_SW     = 8'd0;
    localparam logic [7:0] OFS_LED    = 8'd1;
    localparam logic [7:0] OFS_CNT_LO = 8'd2;
    localparam logic [7:0] OFS_CNT_HI = 8'd3;
    localparam logic [7:0] OFS_STATUS = 8'd4;

endpackage

// File: rtl/mem_io_responder_ram.sv
// rtl/mem_io_responder_ram.sv - single-port synchronous RAM backing the low address range
module resp_ram
    import mem_io_responder_pkg::*;
#(
    parameter int DEPTH = RAM_DEPTH
) (
    input  logic       clock,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);

    logic [7:0] mem [0:DEPTH-1];

    // Registered read of the addressed word every cycle; write when enabled
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - variable-latency RAM and memory-mapped I/O responder
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int         RAM_WAIT = 1,
    parameter logic [7:0] IO_BASE  = DEFAULT_IO_BASE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       MemRead,
    input  logic       MemWrite,
    input  logic [7:0] address,
    input  logic [7:0] data,
    output logic [7:0] q,
    output logic       ready,
    input  logic [4:0] sw_in,
    output logic [7:0] led_out,
    output logic       err
);

    state_t      state, state_nxt;
    logic [2:0]  wait_cnt;
    logic        lat_write, lat_ram;
    logic [7:0]  lat_addr, lat_data;
    logic [7:0]  io_rdata, io_q, q_reg, rd_value, ram_rdata;
    logic [15:0] counter;
    logic [7:0]  snapshot;
    logic [4:0]  sw_meta, sw_sync;
    logic        err_r;
    logic        ram_we;

    logic       req, accept, addr_is_ram, acc_bad;
    logic [7:0] acc_ofs, lat_ofs;
    logic       io_capture, done_rd, done_wr;

    assign req         = MemRead | MemWrite;
    assign accept      = (state == IDLE) && req;
    assign addr_is_ram = (address < IO_BASE);
    assign acc_ofs     = address - IO_BASE;
    assign acc_bad     = !addr_is_ram && (acc_ofs > OFS_STATUS);
    assign lat_ofs     = lat_addr - IO_BASE;

    // I/O read value is sampled on the last WAIT cycle, same edge the RAM read lands
    assign io_capture  = (state == WAIT) && (wait_cnt == 3'd0) && !lat_write && !lat_ram;
    assign done_rd     = (state == DONE) && !lat_write;
    assign done_wr     = (state == DONE) && lat_write;

    assign rd_value    = lat_ram ? ram_rdata : io_q;
    assign q           = done_rd ? rd_value : q_reg;
    assign err         = err_r;

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, completion pulse and RAM write strobe
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        ram_we    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 3'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ready     = 1'b1;
                ram_we    = lat_write && lat_ram;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the request on acceptance and count down the wait cycles
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_addr  <= 8'h00;
            lat_data  <= 8'h00;
            lat_write <= 1'b0;
            lat_ram   <= 1'b0;
            wait_cnt  <= 3'd0;
        end else if (accept) begin
            lat_addr  <= address;
            lat_data  <= data;
            lat_write <= MemWrite;
            lat_ram   <= addr_is_ram;
            wait_cnt  <= addr_is_ram ? 3'(RAM_WAIT) : 3'd0;
        end else if ((state == WAIT) && (wait_cnt != 3'd0)) begin
            wait_cnt <= wait_cnt - 3'd1;
        end
    end

    // Decode the I/O register being read
    always_comb begin
        io_rdata = 8'h00;
        case (lat_ofs)
            OFS_SW:     io_rdata = {3'b000, sw_sync};
            OFS_LED:    io_rdata = led_out;
            OFS_CNT_LO: io_rdata = counter[7:0];
            OFS_CNT_HI: io_rdata = snapshot;
            OFS_STATUS: io_rdata = {7'b0, err_r};
            default:    io_rdata = 8'h00;
        endcase
    end

    // Capture I/O read data; a CNT_LO read freezes the upper counter byte for CNT_HI
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_q     <= 8'h00;
            snapshot <= 8'h00;
        end else if (io_capture) begin
            io_q <= io_rdata;
            if (lat_ofs == OFS_CNT_LO) begin
                snapshot <= counter[15:8];
            end
        end
    end

    // Hold the last completed read value on q between reads
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_reg <= 8'h00;
        end else if (done_rd) begin
            q_reg <= rd_value;
        end
    end

    // LED register write commits on the DONE edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led_out <= 8'h00;
        end else if (done_wr && !lat_ram && (lat_ofs == OFS_LED)) begin
            led_out <= lat_data;
        end
    end

    // Sticky error: set on dual request or unmapped I/O offset, set wins over clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (accept && ((MemRead && MemWrite) || acc_bad)) begin
            err_r <= 1'b1;
        end else if (done_wr && !lat_ram && (lat_ofs == OFS_STATUS) && lat_data[0]) begin
            err_r <= 1'b0;
        end
    end

    // Free-running 16-bit cycle counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter <= 16'h0000;
        end else begin
            counter <= counter + 16'h0001;
        end
    end

    // Two-flop synchroniser for the slide switches
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_meta <= 5'b0;
            sw_sync <= 5'b0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
        end
    end

    resp_ram #(
        .DEPTH(RAM_DEPTH)
    ) u_ram (
        .clock(clock),
        .we   (ram_we),
        .addr (lat_addr),
        .wdata(lat_data),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - scoreboard bench for the data-memory responder
module tb_mem_io_responder;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       MemRead = 1'b0;
    logic       MemWrite = 1'b0;
    logic [7:0] address = 8'h00;
    logic [7:0] data = 8'h00;
    logic [4:0] sw_in = 5'b0;
    logic [7:0] q;
    logic       ready;
    logic [7:0] led_out;
    logic       err;

    always #5 clock = ~clock;

    mem_io_responder #(
        .RAM_WAIT(1),
        .IO_BASE (8'hF0)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .MemRead (MemRead),
        .MemWrite(MemWrite),
        .address (address),
        .data    (data),
        .q       (q),
        .ready   (ready),
        .sw_in   (sw_in),
        .led_out (led_out),
        .err     (err)
    );

    typedef struct {
        int         id;
        logic       chk_q;
        logic [7:0] exp_q;
        int         exp_cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          next_id = 0;
    logic [15:0] tb_cnt;
    logic [7:0]  snap_exp = 8'h00;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock or posedge reset) begin
        if (reset) tb_cnt <= 16'h0000;
        else       tb_cnt <= tb_cnt + 16'h0001;
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready at cycle %0d: got ready=1 expected no pending request", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk($sformatf("latency#%0d", mon_e.id), cyc[15:0], mon_e.exp_cyc[15:0]);
                if (mon_e.chk_q) begin
                    chk($sformatf("q#%0d", mon_e.id), {8'h00, q}, {8'h00, mon_e.exp_q});
                end
            end
        end
    end

    // cnt_sel: 0 = use exp_q, 1 = expect counter low byte, 2 = expect snapshot
    task automatic do_req(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d,
                          input logic chk_q, input logic [7:0] exp_q, input int cnt_sel);
        exp_t        e;
        logic        got;
        logic [15:0] cnt_p1;
        @(posedge clock);
        #1;
        e.id      = next_id;
        next_id++;
        e.chk_q   = chk_q;
        e.exp_q   = exp_q;
        e.exp_cyc = cyc + 2 + ((a < 8'hF0) ? 1 : 0);
        cnt_p1    = tb_cnt + 16'h0001;
        if (cnt_sel == 1) begin
            e.exp_q  = cnt_p1[7:0];
            snap_exp = cnt_p1[15:8];
        end else if (cnt_sel == 2) begin
            e.exp_q = snap_exp;
        end
        sb.push_back(e);
        MemRead  = rd;
        MemWrite = wr;
        address  = a;
        data     = d;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout#%0d: got no ready expected ready within 20 cycles", e.id);
            e = sb.pop_back();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_seen;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_q", {8'h00, q}, 16'h0000);
        chk("reset_ready", {15'h0, ready}, 16'h0000);
        chk("reset_led", {8'h00, led_out}, 16'h0000);
        chk("reset_err", {15'h0, err}, 16'h0000);
        reset = 1'b0;

        // RAM write then read, 3-cycle latency
        do_req(1'b0, 1'b1, 8'h10, 8'h5A, 1'b0, 8'h00, 0);
        do_req(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 8'h5A, 0);

        // LED write and readback, 2-cycle latency
        do_req(1'b0, 1'b1, 8'hF1, 8'hC3, 1'b0, 8'h00, 0);
        @(posedge clock);
        #1;
        chk("led_after_write", {8'h00, led_out}, 16'h00C3);
        do_req(1'b1, 1'b0, 8'hF1, 8'h00, 1'b1, 8'hC3, 0);

        // Switches through the synchroniser
        sw_in = 5'b10110;
        repeat (3) @(posedge clock);
        do_req(1'b1, 1'b0, 8'hF0, 8'h00, 1'b1, 8'h16, 0);

        // Cycle counter with high-byte snapshot
        repeat (300) @(posedge clock);
        do_req(1'b1, 1'b0, 8'hF2, 8'h00, 1'b1, 8'h00, 1);
        do_req(1'b1, 1'b0, 8'hF3, 8'h00, 1'b1, 8'h00, 2);
        repeat (7) @(posedge clock);
        do_req(1'b1, 1'b0, 8'hF2, 8'h00, 1'b1, 8'h00, 1);
        do_req(1'b1, 1'b0, 8'hF3, 8'h00, 1'b1, 8'h00, 2);

        // Error flag: unmapped read sets, status reads it, write 1 clears
        do_req(1'b1, 1'b0, 8'hF9, 8'h00, 1'b1, 8'h00, 0);
        chk("err_after_unmapped", {15'h0, err}, 16'h0001);
        do_req(1'b1, 1'b0, 8'hF4, 8'h00, 1'b1, 8'h01, 0);
        do_req(1'b0, 1'b1, 8'hF4, 8'h01, 1'b0, 8'h00, 0);
        @(posedge clock);
        #1;
        chk("err_cleared", {15'h0, err}, 16'h0000);

        // Simultaneous read and write is a write and flags an error
        do_req(1'b1, 1'b1, 8'h30, 8'h77, 1'b0, 8'h00, 0);
        chk("err_dual_req", {15'h0, err}, 16'h0001);
        do_req(1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 8'h77, 0);

        // Reset during WAIT of a RAM write aborts without ready or commit
        do_req(1'b0, 1'b1, 8'h20, 8'h11, 1'b0, 8'h00, 0);
        @(posedge clock);
        #1;
        MemWrite = 1'b1;
        address  = 8'h20;
        data     = 8'hFF;
        @(posedge clock);
        #1;
        reset = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (ready !== 1'b0) rdy_seen++;
        end
        MemWrite = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (ready !== 1'b0) rdy_seen++;
        end
        chk("abort_no_ready", rdy_seen[15:0], 16'h0000);
        chk("abort_led_reset", {8'h00, led_out}, 16'h0000);
        chk("abort_err_reset", {15'h0, err}, 16'h0000);
        do_req(1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 8'h11, 0);

        repeat (3) @(posedge clock);
        chk("scoreboard_empty", 16'(sb.size()), 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
